// File: rtl/alu_4b.sv
// alu_4b: handshake-driven 8-bit ALU with an 8-cycle shift-add multiplier and held result
module alu_4b (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  op,
   input  logic [3:0]  a1,
   input  logic [3:0]  a2,
   input  logic [3:0]  b1,
   input  logic [3:0]  b2,
   input  logic        rx_valid,
   output logic        alu_ready,
   output logic [15:0] result,
   output logic        err,
   output logic        zero,
   output logic        alu_valid,
   input  logic        tx_ready
);
   typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
   state_t      state;
   logic [3:0]  op_r;
   logic [15:0] mcand;
   logic [7:0]  mplier;
   logic [15:0] acc;
   logic [2:0]  cnt;
   logic [7:0]  a_r;
   logic [15:0] alu_res;
   logic        alu_err;
   logic [15:0] mul_sum;
   assign a_r = mcand[7:0];
   // single-cycle datapath on the latched operands; mcand/mplier double as A/B outside MUL
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      mul_sum = acc + (mplier[0] ? mcand : 16'h0000);
      case (op_r)
         4'h0: alu_res = {8'h00, a_r} + {8'h00, mplier};
         4'h1: alu_res = {8'h00, a_r} - {8'h00, mplier};
         4'h3: alu_res = {8'h00, a_r & mplier};
         4'h4: alu_res = {8'h00, a_r | mplier};
         4'h5: alu_res = {8'h00, a_r ^ mplier};
         4'h6: alu_res = {8'h00, a_r} << mplier[2:0];
         4'h7: alu_res = {8'h00, a_r >> mplier[2:0]};
         4'h8: alu_res = {14'b0, a_r > mplier, a_r == mplier};
         4'h2: alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end
   // control FSM with registered handshake outputs and result hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         alu_ready <= 1'b1;
         alu_valid <= 1'b0;
         result    <= '0;
         err       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (rx_valid) begin
               op_r      <= op;
               mcand     <= {8'h00, a1, a2};
               mplier    <= {b1, b2};
               acc       <= '0;
               cnt       <= '0;
               alu_ready <= 1'b0;
               state     <= (op == 4'h2) ? MUL : EXEC;
            end
            EXEC: begin
               result    <= alu_res;
               err       <= alu_err;
               zero      <= (alu_res == 16'h0000);
               alu_valid <= 1'b1;
               state     <= DONE;
            end
            MUL: begin
               acc    <= mul_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  result    <= mul_sum;
                  err       <= 1'b0;
                  zero      <= (mul_sum == 16'h0000);
                  alu_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (tx_ready) begin
               alu_valid <= 1'b0;
               alu_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule
